// File: rtl/rom_dl_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : rom_dl_sequencer
// Purpose  : Buffers index-0 ioctl ROM bytes, replays them as paced dn_wr
//            writes and holds the core in reset until the load has settled.
//            Optional macro: ROM_CHECKSUM_EN (adds rom_sum / EXPECTED_SUM).
// Revision : 1.0 - initial release
// ============================================================================
module rom_dl_sequencer #(
    parameter int          FIFO_AW      = 3,
    parameter int          WR_SPACING   = 4,
    parameter int          RESET_HOLD   = 16,
    parameter logic [16:0] EXPECTED_LEN = 17'd40960
`ifdef ROM_CHECKSUM_EN
    ,
    parameter logic [15:0] EXPECTED_SUM = 16'h0000
`endif
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic [15:0] dn_addr,
    output logic [7:0]  dn_data,
    output logic        dn_wr,
    output logic        core_reset,
    output logic        dl_busy,
    output logic        dl_done,
    output logic        dl_error,
    output logic [16:0] byte_count
`ifdef ROM_CHECKSUM_EN
    ,
    output logic [15:0] rom_sum
`endif
);

    localparam int c_DEPTH  = 1 << FIFO_AW;
    localparam int c_SP_W   = (WR_SPACING > 1) ? $clog2(WR_SPACING) : 1;
    localparam int c_HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
    localparam logic [c_SP_W-1:0]   c_SP_RELOAD   = c_SP_W'(WR_SPACING - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_RELOAD = c_HOLD_W'(RESET_HOLD - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    state_t              r_state;
    logic [23:0]         r_fifo_mem [0:c_DEPTH-1];
    logic [FIFO_AW:0]    r_wr_ptr;
    logic [FIFO_AW:0]    r_rd_ptr;
    logic [c_SP_W-1:0]   r_sp_cnt;
    logic [c_HOLD_W-1:0] r_hold_cnt;
    logic                r_trig_q;
    logic                r_range_err;
    logic                r_ovf_err;

    logic        w_trig;
    logic        w_restart;
    logic        w_empty;
    logic        w_full;
    logic        w_accept;
    logic        w_in_range;
    logic        w_push;
    logic        w_pop;
    logic        w_done_ok;
    logic [23:0] w_head;

    assign w_trig     = ioctl_download & (ioctl_index == 8'd0);
    // A fresh index-0 download outside LOAD (re)starts the load, aborting any drain/hold.
    assign w_restart  = w_trig & ~r_trig_q & (r_state != ST_LOAD);
    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_full     = (r_wr_ptr[FIFO_AW] != r_rd_ptr[FIFO_AW]) &&
                        (r_wr_ptr[FIFO_AW-1:0] == r_rd_ptr[FIFO_AW-1:0]);
    assign w_accept   = (r_state == ST_LOAD) & w_trig & ioctl_wr;
    assign w_in_range = (ioctl_addr[24:16] == 9'd0);
    assign w_push     = w_accept & w_in_range & ~w_full;
    assign w_pop      = ((r_state == ST_LOAD) || (r_state == ST_DRAIN)) &&
                        !w_empty && (r_sp_cnt == '0) && !w_restart;
    assign w_head     = r_fifo_mem[r_rd_ptr[FIFO_AW-1:0]];

`ifdef ROM_CHECKSUM_EN
    logic [15:0] r_rom_sum;
    assign rom_sum   = r_rom_sum;
    assign w_done_ok = (byte_count == EXPECTED_LEN) && !r_range_err && !r_ovf_err &&
                       (r_rom_sum == EXPECTED_SUM);
`else
    assign w_done_ok = (byte_count == EXPECTED_LEN) && !r_range_err && !r_ovf_err;
`endif

    always_ff @(posedge clk_sys) begin
        if (w_push) begin
            r_fifo_mem[r_wr_ptr[FIFO_AW-1:0]] <= {ioctl_addr[15:0], ioctl_dout};
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_sp_cnt    <= '0;
            r_hold_cnt  <= '0;
            r_trig_q    <= 1'b0;
            r_range_err <= 1'b0;
            r_ovf_err   <= 1'b0;
            dn_addr     <= 16'd0;
            dn_data     <= 8'd0;
            dn_wr       <= 1'b0;
            core_reset  <= 1'b1;
            dl_busy     <= 1'b0;
            dl_done     <= 1'b0;
            dl_error    <= 1'b0;
            byte_count  <= 17'd0;
`ifdef ROM_CHECKSUM_EN
            r_rom_sum   <= 16'd0;
`endif
        end else begin
            r_trig_q <= w_trig;
            dn_wr    <= 1'b0;
            if (r_sp_cnt != '0) begin
                r_sp_cnt <= r_sp_cnt - 1'b1;
            end

            if (w_restart) begin
                r_state     <= ST_LOAD;
                r_wr_ptr    <= '0;
                r_rd_ptr    <= '0;
                r_range_err <= 1'b0;
                r_ovf_err   <= 1'b0;
                core_reset  <= 1'b1;
                dl_busy     <= 1'b1;
                dl_done     <= 1'b0;
                dl_error    <= 1'b0;
                byte_count  <= 17'd0;
`ifdef ROM_CHECKSUM_EN
                r_rom_sum   <= 16'd0;
`endif
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                    if (byte_count != 17'h1FFFF) begin
                        byte_count <= byte_count + 17'd1;
                    end
                end
                if (w_accept && !w_in_range) begin
                    r_range_err <= 1'b1;
                end
                if (w_accept && w_in_range && w_full) begin
                    r_ovf_err <= 1'b1;
                end

                if (w_pop) begin
                    dn_addr  <= w_head[23:8];
                    dn_data  <= w_head[7:0];
                    dn_wr    <= 1'b1;
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                    r_sp_cnt <= c_SP_RELOAD;
`ifdef ROM_CHECKSUM_EN
                    r_rom_sum <= r_rom_sum + {8'd0, w_head[7:0]};
`endif
                end

                case (r_state)
                    ST_LOAD: begin
                        if (!ioctl_download) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                    ST_DRAIN: begin
                        if (w_empty && (r_sp_cnt == '0)) begin
                            r_state    <= ST_HOLD;
                            r_hold_cnt <= c_HOLD_RELOAD;
                        end
                    end
                    ST_HOLD: begin
                        if (r_hold_cnt == '0) begin
                            r_state    <= ST_IDLE;
                            dl_busy    <= 1'b0;
                            core_reset <= 1'b0;
                            dl_done    <= w_done_ok;
                            dl_error   <= !w_done_ok;
                        end else begin
                            r_hold_cnt <= r_hold_cnt - 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rom_dl_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rom_dl_sequencer
// Purpose  : Self-checking bench for rom_dl_sequencer (ROM_CHECKSUM_EN aware).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rom_dl_sequencer;

    localparam int          c_AW   = 3;
    localparam int          c_SP   = 4;
    localparam int          c_HOLD = 16;
    localparam logic [16:0] c_LEN  = 17'd64;
`ifdef ROM_CHECKSUM_EN
    localparam logic [15:0] c_SUM  = 16'h1234;
`endif

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        ioctl_download = 1'b0;
    logic [7:0]  ioctl_index = 8'd0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = 25'd0;
    logic [7:0]  ioctl_dout = 8'd0;
    logic [15:0] dn_addr;
    logic [7:0]  dn_data;
    logic        dn_wr;
    logic        core_reset;
    logic        dl_busy;
    logic        dl_done;
    logic        dl_error;
    logic [16:0] byte_count;
`ifdef ROM_CHECKSUM_EN
    logic [15:0] rom_sum;
`endif

    rom_dl_sequencer #(
        .FIFO_AW      (c_AW),
        .WR_SPACING   (c_SP),
        .RESET_HOLD   (c_HOLD),
        .EXPECTED_LEN (c_LEN)
`ifdef ROM_CHECKSUM_EN
        , .EXPECTED_SUM (c_SUM)
`endif
    ) dut (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .dn_addr        (dn_addr),
        .dn_data        (dn_data),
        .dn_wr          (dn_wr),
        .core_reset     (core_reset),
        .dl_busy        (dl_busy),
        .dl_done        (dl_done),
        .dl_error       (dl_error),
        .byte_count     (byte_count)
`ifdef ROM_CHECKSUM_EN
        , .rom_sum      (rom_sum)
`endif
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        int          nbytes;
        int          gap;
        int          bad_idx;
        logic [16:0] exp_count;
        bit          exp_done;
        bit          exp_err;
    } vec_t;

    int          n_vec = 0;
    int          n_err = 0;
    int          n_wr  = 0;
    logic [23:0] exp_q[$];
    logic [23:0] mon_e;
    logic [15:0] m_sum = 16'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference scoreboard: every dn_wr must match the next accepted byte in order.
    always @(negedge clk_sys) begin
        if (reset_n && dn_wr) begin
            n_wr++;
            if (exp_q.size() == 0) begin
                check("unexpected_dn_wr", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                m_sum = m_sum + {8'd0, mon_e[7:0]};
                check("dn_addr", {16'd0, dn_addr}, {16'd0, mon_e[23:8]});
                check("dn_data", {24'd0, dn_data}, {24'd0, mon_e[7:0]});
            end
        end
    end

    task automatic start_load();
        @(negedge clk_sys);
        ioctl_index    = 8'd0;
        ioctl_download = 1'b1;
        @(negedge clk_sys);
        exp_q.delete();
        m_sum = 16'd0;
        n_wr  = 0;
    endtask

    task automatic send_byte(input logic [24:0] a, input logic [7:0] d, input bit acc, input int gap);
        @(negedge clk_sys);
        ioctl_wr   = 1'b1;
        ioctl_addr = a;
        ioctl_dout = d;
        if (acc) exp_q.push_back({a[15:0], d});
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
        repeat (gap - 1) @(negedge clk_sys);
    endtask

    task automatic end_load(output int cyc);
        @(negedge clk_sys);
        ioctl_download = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk_sys);
            cyc++;
        end while (core_reset && cyc < 300);
        check("core_reset_released", {31'd0, core_reset}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t        vecs[6];
        int          cyc;
        int          k;
        bit          last_done;
        logic [16:0] last_count;
        logic [15:0] last_addr;
        bit          exp_done;
        int          wr_before;

        vecs[0] = '{64, 8, -1, 17'd64, 1'b1, 1'b0};
        vecs[1] = '{63, 5, -1, 17'd63, 1'b0, 1'b1};
        vecs[2] = '{65, 4, 10, 17'd64, 1'b0, 1'b1};
        vecs[3] = '{65, 6, -1, 17'd65, 1'b0, 1'b1};
        vecs[4] = '{64, 4, 63, 17'd63, 1'b0, 1'b1};
        vecs[5] = '{64, 4, -1, 17'd64, 1'b1, 1'b0};

        // Reset with no download
        repeat (3) @(negedge clk_sys);
        check("rst_core_reset", {31'd0, core_reset}, 32'd1);
        reset_n = 1'b1;
        repeat (10) @(negedge clk_sys);
        check("idle_core_reset", {31'd0, core_reset}, 32'd1);
        check("idle_busy", {31'd0, dl_busy}, 32'd0);
        check("idle_done", {31'd0, dl_done}, 32'd0);
        check("idle_error", {31'd0, dl_error}, 32'd0);
        check("idle_count", {15'd0, byte_count}, 32'd0);
        check("idle_dn_addr", {16'd0, dn_addr}, 32'd0);
        check("idle_no_wr", n_wr, 0);

        last_done  = 1'b0;
        last_count = 17'd0;
        last_addr  = 16'd0;
        for (int v = 0; v < 6; v++) begin
            start_load();
            check("entry_count", {15'd0, byte_count}, 32'd0);
            check("entry_busy", {31'd0, dl_busy}, 32'd1);
            check("entry_core_reset", {31'd0, core_reset}, 32'd1);
            k = 0;
            for (int i = 0; i < vecs[v].nbytes; i++) begin
                if (i == vecs[v].bad_idx) begin
                    send_byte(25'h10000 + 25'(k), 8'($urandom), 1'b0,
                              vecs[v].gap + int'($urandom_range(0, 3)));
                end else begin
                    send_byte(25'(k), 8'($urandom), 1'b1,
                              vecs[v].gap + int'($urandom_range(0, 3)));
                    last_addr = 16'(k);
                    k++;
                end
            end
            repeat (8) @(negedge clk_sys);
            check("drained", exp_q.size(), 0);
            check("dn_addr_hold", {16'd0, dn_addr}, {16'd0, last_addr});
            end_load(cyc);
            // LOAD sees the fall, one DRAIN cycle, then RESET_HOLD cycles of HOLD
            check("hold_cycles", cyc, c_HOLD + 2);
            exp_done = vecs[v].exp_done;
`ifdef ROM_CHECKSUM_EN
            exp_done = exp_done && (m_sum == c_SUM);
            check("rom_sum", {16'd0, rom_sum}, {16'd0, m_sum});
`endif
            check("wr_count", n_wr, int'(vecs[v].exp_count));
            check("byte_count", {15'd0, byte_count}, {15'd0, vecs[v].exp_count});
            check("dl_done", {31'd0, dl_done}, {31'd0, exp_done});
            check("dl_error", {31'd0, dl_error}, {31'd0, !exp_done});
            check("end_busy", {31'd0, dl_busy}, 32'd0);
            last_done  = exp_done;
            last_count = vecs[v].exp_count;
        end

        // Non-zero index download is ignored
        wr_before = n_wr;
        @(negedge clk_sys);
        ioctl_index    = 8'd1;
        ioctl_download = 1'b1;
        for (int i = 0; i < 5; i++) send_byte(25'(i), 8'(i + 1), 1'b0, 2);
        check("idx1_busy", {31'd0, dl_busy}, 32'd0);
        check("idx1_core_reset", {31'd0, core_reset}, 32'd0);
        check("idx1_done", {31'd0, dl_done}, {31'd0, last_done});
        check("idx1_count", {15'd0, byte_count}, {15'd0, last_count});
        check("idx1_no_wr", n_wr, wr_before);
        @(negedge clk_sys);
        ioctl_download = 1'b0;
        ioctl_index    = 8'd0;
        repeat (2) @(negedge clk_sys);

        // Back-to-back burst of 12 into an 8-deep FIFO paced every 4 cycles:
        // pops land 1, 5 and 9 cycles after the first push, so the 12th push meets a full FIFO.
        start_load();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_sys);
            if (i == 1) check("latency_early", {31'd0, dn_wr}, 32'd0);
            if (i == 2) begin
                check("latency_first", {31'd0, dn_wr}, 32'd1);
                check("latency_addr", {16'd0, dn_addr}, 32'h100);
            end
            ioctl_wr   = 1'b1;
            ioctl_addr = 25'h100 + 25'(i);
            ioctl_dout = 8'($urandom);
            if (i < 11) exp_q.push_back({ioctl_addr[15:0], ioctl_dout});
        end
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
        end_load(cyc);
        check("ovf_wr_count", n_wr, 11);
        check("ovf_count", {15'd0, byte_count}, 32'd11);
        check("ovf_done", {31'd0, dl_done}, 32'd0);
        check("ovf_error", {31'd0, dl_error}, 32'd1);

        // Restart during HOLD
        start_load();
        for (int i = 0; i < 3; i++) send_byte(25'(i), 8'($urandom), 1'b1, 4);
        repeat (6) @(negedge clk_sys);
        ioctl_download = 1'b0;
        repeat (8) @(negedge clk_sys);
        check("in_hold_busy", {31'd0, dl_busy}, 32'd1);
        check("in_hold_core_reset", {31'd0, core_reset}, 32'd1);
        start_load();
        check("abort_count", {15'd0, byte_count}, 32'd0);
        check("abort_done", {31'd0, dl_done}, 32'd0);
        check("abort_error", {31'd0, dl_error}, 32'd0);
        check("abort_core_reset", {31'd0, core_reset}, 32'd1);

        // Restart during DRAIN with bytes still queued: remainder must be discarded
        for (int i = 0; i < 6; i++) send_byte(25'h40 + 25'(i), 8'($urandom), 1'b1, 1);
        @(negedge clk_sys);
        ioctl_download = 1'b0;
        start_load();
        repeat (12) @(negedge clk_sys);
        check("flush_no_stale_wr", n_wr, 0);
        check("flush_count", {15'd0, byte_count}, 32'd0);
        end_load(cyc);
        check("empty_load_error", {31'd0, dl_error}, 32'd1);
        check("empty_load_done", {31'd0, dl_done}, 32'd0);

`ifdef ROM_CHECKSUM_EN
        start_load();
        send_byte(25'd0, 8'h01, 1'b1, 5);
        send_byte(25'd1, 8'h02, 1'b1, 5);
        send_byte(25'd2, 8'hFF, 1'b1, 5);
        repeat (6) @(negedge clk_sys);
        check("sum_0102", {16'd0, rom_sum}, 32'h0102);
        end_load(cyc);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
